// File: rtl/up_down_counter_param.sv
// up_down_counter_param
// Parametrised up/down counter with programmable modulus (0..MAX_VAL),
// optional saturation, parallel load with clamping, count enable,
// terminal-count, one-cycle boundary pulse and sticky overflow flag.
//
// Parameters:
//   WIDTH    counter width in bits (2..32)
//   MAX_VAL  highest count value, 1 <= MAX_VAL <= 2**WIDTH-1
//   SATURATE 0 = wrap at the boundaries, 1 = hold at the boundaries
//
// Ports:
//   clk      rising-edge clock
//   rst      synchronous active-high reset (q <= 0 when counting up,
//            q <= MAX_VAL when counting down)
//   en       count enable
//   mode     direction: 1 = up, 0 = down
//   load     parallel load strobe (priority over en)
//   load_val value to load, clamped to MAX_VAL
//   clr_ovf  clears the sticky overflow flag (a simultaneous set wins)
//   q        registered count
//   tc       terminal count, combinational from q and mode
//   wrap_p   registered pulse, high the cycle after each boundary event
//   ovf      registered sticky boundary-event flag
module up_down_counter_param #(
   parameter int unsigned      WIDTH    = 8,
   parameter logic [WIDTH-1:0] MAX_VAL  = '1,
   parameter bit               SATURATE = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             mode,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             clr_ovf,
   output logic [WIDTH-1:0] q,
   output logic             tc,
   output logic             wrap_p,
   output logic             ovf
);

   localparam logic [WIDTH:0] MAX_EXT = {1'b0, MAX_VAL};

   logic [WIDTH:0]   inc_ext;
   logic [WIDTH:0]   dec_ext;
   logic             at_top;
   logic             at_bot;
   logic             boundary;
   logic [WIDTH-1:0] q_nxt;

   // Boundary detection uses the extra arithmetic bit: q+1 exceeds
   // MAX_VAL only at the top, and q-1 borrows only at zero.
   always_comb begin
      inc_ext = {1'b0, q} + 1'b1;
      dec_ext = {1'b0, q} - 1'b1;
      at_top  = (inc_ext > MAX_EXT);
      at_bot  = dec_ext[WIDTH];
   end

   assign tc = mode ? at_top : at_bot;

   always_comb begin
      boundary = 1'b0;
      q_nxt    = q;
      if (load) begin
         q_nxt = ({1'b0, load_val} > MAX_EXT) ? MAX_VAL : load_val;
      end else if (en) begin
         if (mode) begin
            if (at_top) begin
               boundary = 1'b1;
               q_nxt    = SATURATE ? MAX_VAL : '0;
            end else begin
               q_nxt = inc_ext[WIDTH-1:0];
            end
         end else begin
            if (at_bot) begin
               boundary = 1'b1;
               q_nxt    = SATURATE ? '0 : MAX_VAL;
            end else begin
               q_nxt = dec_ext[WIDTH-1:0];
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         q      <= mode ? '0 : MAX_VAL;
         wrap_p <= 1'b0;
         ovf    <= 1'b0;
      end else begin
         q      <= q_nxt;
         wrap_p <= boundary;
         // set wins over a same-cycle clear
         ovf    <= boundary | (ovf & ~clr_ovf);
      end
   end

endmodule

// File: tb/tb_up_down_counter_param.sv
// Testbench for up_down_counter_param: directed vector table (wrapping
// instance), hand-written saturation sequence, and randomized stimulus
// checked against an integer-level reference model for both instances.
module tb_up_down_counter_param;

   localparam int W  = 3;
   localparam int MX = 5;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst, en, mode, load, clr;
   logic [W-1:0] lv;
   logic [W-1:0] q0, q1;
   logic         tc0, tc1, w0, w1, o0, o1;

   up_down_counter_param #(.WIDTH(W), .MAX_VAL(3'd5), .SATURATE(1'b0)) dut0 (
      .clk(clk), .rst(rst), .en(en), .mode(mode), .load(load),
      .load_val(lv), .clr_ovf(clr), .q(q0), .tc(tc0), .wrap_p(w0), .ovf(o0)
   );

   up_down_counter_param #(.WIDTH(W), .MAX_VAL(3'd5), .SATURATE(1'b1)) dut1 (
      .clk(clk), .rst(rst), .en(en), .mode(mode), .load(load),
      .load_val(lv), .clr_ovf(clr), .q(q1), .tc(tc1), .wrap_p(w1), .ovf(o1)
   );

   int ntests = 0;
   int nfail  = 0;

   task automatic chk(input string name, input int act, input int exp);
      ntests++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // reference model: index 0 = wrapping, 1 = saturating
   int mq [2];
   int mw [2];
   int mo [2];

   function automatic int model_tc(input int c);
      return mode ? int'(mq[c] == MX) : int'(mq[c] == 0);
   endfunction

   task automatic model_step();
      for (int c = 0; c < 2; c++) begin
         int ev = 0;
         if (rst) begin
            mq[c] = mode ? 0 : MX;
            mw[c] = 0;
            mo[c] = 0;
         end else begin
            if (load) begin
               mq[c] = (int'(lv) > MX) ? MX : int'(lv);
            end else if (en) begin
               if (mode) begin
                  if (mq[c] == MX) begin ev = 1; mq[c] = (c == 1) ? MX : 0; end
                  else mq[c] = mq[c] + 1;
               end else begin
                  if (mq[c] == 0) begin ev = 1; mq[c] = (c == 1) ? 0 : MX; end
                  else mq[c] = mq[c] - 1;
               end
            end
            mw[c] = ev;
            mo[c] = (ev != 0 || (mo[c] != 0 && !clr)) ? 1 : 0;
         end
      end
   endtask

   task automatic drive(input bit r, input bit e, input bit m, input bit l,
                        input int v, input bit c);
      rst = r; en = e; mode = m; load = l; lv = W'(v); clr = c;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      model_step();
   endtask

   task automatic check_model();
      chk("rand_q0",  int'(q0),  mq[0]);
      chk("rand_w0",  int'(w0),  mw[0]);
      chk("rand_o0",  int'(o0),  mo[0]);
      chk("rand_tc0", int'(tc0), model_tc(0));
      chk("rand_q1",  int'(q1),  mq[1]);
      chk("rand_w1",  int'(w1),  mw[1]);
      chk("rand_o1",  int'(o1),  mo[1]);
      chk("rand_tc1", int'(tc1), model_tc(1));
   endtask

   typedef struct {
      bit r, e, m, l;
      int v;
      bit c;
      int q, w, o, t;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(input bit r, input bit e, input bit m, input bit l,
                               input int v, input bit c,
                               input int q, input int w, input int o, input int t);
      vec_t x;
      x.r = r; x.e = e; x.m = m; x.l = l; x.v = v; x.c = c;
      x.q = q; x.w = w; x.o = o; x.t = t;
      return x;
   endfunction

   initial begin
      bit rm;
      drive(0, 0, 1, 0, 0, 0);
      for (int i = 0; i < 2; i++) begin mq[i] = 0; mw[i] = 0; mo[i] = 0; end

      //            r e m l  v c   q w o t
      // up count with wrap
      tbl.push_back(mk(1,0,1,0, 0,0,  0,0,0,0));
      tbl.push_back(mk(0,1,1,0, 0,0,  1,0,0,0));
      tbl.push_back(mk(0,1,1,0, 0,0,  2,0,0,0));
      tbl.push_back(mk(0,1,1,0, 0,0,  3,0,0,0));
      tbl.push_back(mk(0,1,1,0, 0,0,  4,0,0,0));
      tbl.push_back(mk(0,1,1,0, 0,0,  5,0,0,1));
      tbl.push_back(mk(0,1,1,0, 0,0,  0,1,1,0));
      tbl.push_back(mk(0,1,1,0, 0,0,  1,0,1,0));
      // down count with wrap
      tbl.push_back(mk(1,0,0,0, 0,0,  5,0,0,0));
      tbl.push_back(mk(0,1,0,0, 0,0,  4,0,0,0));
      tbl.push_back(mk(0,1,0,0, 0,0,  3,0,0,0));
      tbl.push_back(mk(0,1,0,0, 0,0,  2,0,0,0));
      tbl.push_back(mk(0,1,0,0, 0,0,  1,0,0,0));
      tbl.push_back(mk(0,1,0,0, 0,0,  0,0,0,1));
      tbl.push_back(mk(0,1,0,0, 0,0,  5,1,1,0));
      tbl.push_back(mk(0,1,0,0, 0,0,  4,0,1,0));
      // hold, then load priority and clamp
      tbl.push_back(mk(0,0,0,0, 0,0,  4,0,1,0));
      tbl.push_back(mk(0,1,1,1, 7,0,  5,0,1,1));
      tbl.push_back(mk(0,1,1,1, 2,0,  2,0,1,0));
      // simultaneous set/clear of ovf
      tbl.push_back(mk(0,0,1,1, 5,0,  5,0,1,1));
      tbl.push_back(mk(0,0,1,0, 0,1,  5,0,0,1));
      tbl.push_back(mk(0,1,1,0, 0,1,  0,1,1,0));
      tbl.push_back(mk(0,0,1,0, 0,1,  0,0,0,0));
      // reset mid-operation overrides load
      tbl.push_back(mk(0,1,0,0, 0,0,  5,1,1,0));
      tbl.push_back(mk(0,0,0,1, 3,0,  3,0,1,0));
      tbl.push_back(mk(1,0,0,1, 1,0,  5,0,0,0));

      foreach (tbl[i]) begin
         drive(tbl[i].r, tbl[i].e, tbl[i].m, tbl[i].l, tbl[i].v, tbl[i].c);
         step();
         chk($sformatf("vec%0d_q", i),  int'(q0),  tbl[i].q);
         chk($sformatf("vec%0d_wrap", i), int'(w0), tbl[i].w);
         chk($sformatf("vec%0d_ovf", i),  int'(o0), tbl[i].o);
         chk($sformatf("vec%0d_tc", i),   int'(tc0), tbl[i].t);
      end

      // saturation sequence on dut1: from 3 count up 5 edges
      drive(0, 0, 1, 1, 3, 0);
      step();
      chk("sat_load_q", int'(q1), 3);
      begin
         int exp_q [5] = '{4, 5, 5, 5, 5};
         int exp_w [5] = '{0, 0, 1, 1, 1};
         for (int k = 0; k < 5; k++) begin
            drive(0, 1, 1, 0, 0, 0);
            step();
            chk($sformatf("sat%0d_q", k), int'(q1), exp_q[k]);
            chk($sformatf("sat%0d_wrap", k), int'(w1), exp_w[k]);
         end
      end
      chk("sat_ovf", int'(o1), 1);
      chk("sat_tc", int'(tc1), 1);
      drive(0, 0, 1, 0, 0, 1);
      step();
      chk("sat_clr_ovf", int'(o1), 0);
      chk("sat_clr_wrap", int'(w1), 0);
      chk("sat_hold_q", int'(q1), 5);
      // zero-latency tc on a direction change at the top
      drive(0, 0, 0, 0, 0, 0);
      #1;
      chk("sat_tc_mode_dn", int'(tc1), 0);

      // randomized phase against the reference model
      drive(1, 0, 1, 0, 0, 0);
      step();
      check_model();
      rm = 1'b1;
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 7) == 0) rm = ~rm;
         drive($urandom_range(0, 40) == 0,
               $urandom_range(0, 3) != 0,
               rm,
               $urandom_range(0, 9) == 0,
               int'($urandom_range(0, 7)),
               $urandom_range(0, 5) == 0);
         #1;
         chk("pre_tc0", int'(tc0), model_tc(0));
         chk("pre_tc1", int'(tc1), model_tc(1));
         step();
         check_model();
      end

      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

endmodule

// File: doc/up_down_counter_param.md
Name: up_down_counter_param

Overview:
Parametrised up/down counter. It generalises the fixed 3-bit up/down counter to any width, a programmable modulus, optional saturation and parallel load. It also adds count-enable, terminal-count, wrap-pulse and sticky overflow status. It is intended as the standard counter primitive for timers, address generators and sequencers in the behavioural library.

Parameters:
WIDTH, 8, counter width in bits (legal range 2..32)
MAX_VAL, 2**WIDTH-1, highest count value; count range is 0..MAX_VAL (must satisfy 1 <= MAX_VAL <= 2**WIDTH-1)
SATURATE, 0, 0 = wrap at the boundaries; 1 = hold at the boundaries

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
en  input  1  count enable
mode  input  1  direction: 1 = up, 0 = down
load  input  1  parallel load strobe
load_val  input  WIDTH  value to load
clr_ovf  input  1  clears the sticky overflow flag
q  output  WIDTH  current count (registered)
tc  output  1  terminal count (combinational from q and mode)
wrap_p  output  1  one-cycle registered boundary-event pulse
ovf  output  1  sticky boundary-event flag (registered)

Behaviour:
- One clock domain; reset is synchronous and active-high, sampled on the rising edge of clk. No asynchronous paths.
- Reset, when rst=1 at an edge:
  - q <= 0 if mode=1, q <= MAX_VAL if mode=0.
  - wrap_p <= 0, ovf <= 0.
  - rst overrides load, en and clr_ovf.
- Update priority for q, per edge: rst > load > en > hold.
- Load, when load=1:
  - q <= min(load_val, MAX_VAL); an out-of-range load clamps to MAX_VAL.
  - Load never produces a boundary event. wrap_p <= 0 that cycle.
- Count, when en=1 and load=0:
  - Up (mode=1): if q < MAX_VAL then q <= q+1. If q == MAX_VAL, this is a boundary event: q <= 0 when SATURATE=0, q holds at MAX_VAL when SATURATE=1.
  - Down (mode=0): if q > 0 then q <= q-1. If q == 0, this is a boundary event: q <= MAX_VAL when SATURATE=0, q holds at 0 when SATURATE=1.
  - Arithmetic is done at WIDTH+1 bits internally. q never holds a value above MAX_VAL, including when MAX_VAL < 2**WIDTH-1.
- Hold: when en=0 and load=0, q is unchanged and wrap_p <= 0.
- tc = (mode && q==MAX_VAL) || (!mode && q==0). tc is combinational and has zero latency with respect to a mode change.
- wrap_p <= 1 for exactly the one cycle after a boundary event, otherwise 0. Consecutive boundary events (for example SATURATE=1 with en held high at the boundary) give a continuous high level.
- ovf:
  - Set on a boundary event.
  - Cleared by clr_ovf=1.
  - A set and a clear in the same cycle leave ovf = 1 (set wins).
  - Otherwise ovf holds.
- A mode change mid-count takes effect on the next enabled edge. There is no reload on a direction change.
- Reset mid-count: q is re-initialised per the mode sampled in that same cycle. Status flags clear.

Test Plan:
1. WIDTH=3, MAX_VAL=5, SATURATE=0: rst=1, mode=1 for one edge -> q=0. Then en=1, mode=1 for 7 edges -> q steps 1,2,3,4,5,0,1. tc=1 while q=5. wrap_p=1 only in the cycle where q=0 after the wrap. ovf=1 afterwards.
2. Same configuration: rst=1, mode=0 -> q=5. Then en=1, mode=0 for 7 edges -> q steps 4,3,2,1,0,5,4. tc=1 while q=0. wrap_p pulses once.
3. SATURATE=1, MAX_VAL=5: count up from 3 for 5 edges -> q = 4,5,5,5,5. wrap_p is high for 3 consecutive cycles. ovf=1. Then pulse clr_ovf -> ovf=0 on the next edge.
4. Load priority and clamp: load=1, load_val=7, en=1 -> q=5 and no wrap_p. Then load=1, load_val=2 with en=1, mode=1 -> q=2, not 3.
5. Simultaneous set and clear of ovf: q=5, mode=1, en=1, clr_ovf=1 -> q=0, ovf=1, wrap_p=1. Then en=0, clr_ovf=1 -> ovf=0.
6. Reset mid-operation: q=3, ovf=1, rst=1, load=1, load_val=1, mode=0 -> q=5, ovf=0, wrap_p=0. The load is ignored.
